// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA text datapath config scheduler.
//  - Screen geometry constants (V_ACTIVE, H_ACTIVE).
//  - cfg_t: config word {rgb[2:0], org_x[9:0], org_y[9:0]} (23 bits).
//  - state_t: commit scheduler FSM states.
//  - RST_CFG: config value after reset (white text, origin 0,0).
package vga_pkg;

    localparam int V_ACTIVE = 480;
    localparam int H_ACTIVE = 640;
    localparam int CFG_W    = 23;

    typedef struct packed {
        logic [2:0] rgb;
        logic [9:0] org_x;
        logic [9:0] org_y;
    } cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COMMIT
    } state_t;

    localparam cfg_t RST_CFG = cfg_t'(23'h700000);

endpackage

// File: rtl/vga_cfg_scheduler_if.sv
// Bus bundle between the two config requesters / renderer and the scheduler.
//  py       line counter from the sync generator
//  req      per-requester request, held high until its gnt pulse
//  cfg_in0  config word offered by requester 0 (switch logic)
//  cfg_in1  config word offered by requester 1 (host/keypad)
//  gnt      one-hot 1-cycle pulse: that requester's word entered the shadow
//  cfg_out  active config driving the character renderer
//  commit   1-cycle pulse: cfg_out was updated this cycle
//  pending  shadow holds a word not yet committed
// Modports: master = requesters/timing side, slave = scheduler.
interface vga_cfg_scheduler_if;
    import vga_pkg::*;

    logic [9:0] py;
    logic [1:0] req;
    cfg_t       cfg_in0;
    cfg_t       cfg_in1;
    logic [1:0] gnt;
    cfg_t       cfg_out;
    logic       commit;
    logic       pending;

    modport master (
        output py, req, cfg_in0, cfg_in1,
        input  gnt, cfg_out, commit, pending
    );

    modport slave (
        input  py, req, cfg_in0, cfg_in1,
        output gnt, cfg_out, commit, pending
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//  req     in   2  active requests
//  rr_ptr  in   1  index of the last winner
//  gnt     out  2  one-hot winner (all zero when nothing requests)
// A single requester always wins; on a tie the requester that did not win
// last time gets the grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_ptr ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/vga_cfg_scheduler.sv
// Frame-synchronous config scheduler. Two requesters compete for a shadow
// register through a round-robin arbiter; the shadow is copied to the active
// config only on entry to vertical blanking, so a frame never tears.
//  clk   in  system clock
//  rst   in  synchronous active-high reset
//  bus   vga_cfg_scheduler_if.slave (py, req, cfg_in0/1, gnt, cfg_out,
//        commit, pending)
// Optional feature macro: VGA_CFG_BLINK_EN -- adds a frame counter that
// blanks the rgb field of cfg_out every other 2^BLINK_LOG2 frames.
module vga_cfg_scheduler
    import vga_pkg::*;
#(
    parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter cfg_t RST_CFG  = vga_pkg::RST_CFG
`ifdef VGA_CFG_BLINK_EN
    ,
    parameter int   BLINK_LOG2 = 5
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_cfg_scheduler_if.slave     bus
);

    localparam logic [9:0] VB_LINE = V_ACTIVE[9:0];

    state_t     state;
    cfg_t       shadow;
    cfg_t       cfg_act;
    logic [1:0] gnt_q;
    logic       commit_q;
    logic       pending_q;
    logic       rr_ptr;
    logic       vb_q;

    logic       vblank;
    logic       vb_rise;
    logic [1:0] req_eff;
    logic [1:0] win;
    logic       grant;

    assign vblank  = (bus.py >= VB_LINE);
    assign vb_rise = vblank & ~vb_q;

    // A requester sees its gnt one cycle after the decision and only then
    // drops req; masking it for that cycle prevents a double grant.
    assign req_eff = bus.req & ~gnt_q;

    rr_arb2 u_arb (
        .req    (req_eff),
        .rr_ptr (rr_ptr),
        .gnt    (win)
    );

    assign grant = |win;

    // Arbitration, shadow capture, vblank edge detect and commit FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= RST_CFG;
            cfg_act   <= RST_CFG;
            gnt_q     <= 2'b00;
            commit_q  <= 1'b0;
            pending_q <= 1'b0;
            rr_ptr    <= 1'b0;
            vb_q      <= 1'b1;   // suppresses a commit on the first partial frame
        end else begin
            vb_q     <= vblank;
            gnt_q    <= win;
            commit_q <= 1'b0;

            if (grant) begin
                shadow    <= win[1] ? bus.cfg_in1 : bus.cfg_in0;
                rr_ptr    <= win[1];
                pending_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant) state <= PENDING;
                end
                PENDING: begin
                    if (vb_rise) begin
                        // Non-blocking copy: a grant on this same edge lands
                        // in the shadow and waits for the next frame.
                        state    <= COMMIT;
                        cfg_act  <= shadow;
                        commit_q <= 1'b1;
                        if (!grant) pending_q <= 1'b0;
                    end
                end
                COMMIT: begin
                    state <= (grant || pending_q) ? PENDING : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.commit  = commit_q;
    assign bus.pending = pending_q;

`ifdef VGA_CFG_BLINK_EN
    logic [BLINK_LOG2:0] frame_cnt;

    // Frame counter advancing once per frame
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (vb_rise) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Only the colour blinks; the origin always follows the committed word.
    always_comb begin
        bus.cfg_out = cfg_act;
        if (frame_cnt[BLINK_LOG2]) bus.cfg_out.rgb = 3'b000;
    end
`else
    assign bus.cfg_out = cfg_act;
`endif

endmodule

// File: tb/tb_vga_cfg_scheduler.sv
module tb_vga_cfg_scheduler;
    import vga_pkg::*;

    localparam int BL = 1;

    localparam cfg_t RSTV = cfg_t'(23'h700000);
    localparam cfg_t W1 = {3'd1, 10'h00A, 10'h014};
    localparam cfg_t W2 = {3'd2, 10'h111, 10'h022};
    localparam cfg_t W3 = {3'd3, 10'h133, 10'h044};
    localparam cfg_t W4 = {3'd4, 10'h055, 10'h066};
    localparam cfg_t W5 = {3'd6, 10'h277, 10'h088};
    localparam cfg_t W6 = {3'd7, 10'h399, 10'h0AA};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_cfg_scheduler_if bus();

    vga_cfg_scheduler #(
        .V_ACTIVE (480),
        .RST_CFG  (RSTV)
`ifdef VGA_CFG_BLINK_EN
        ,
        .BLINK_LOG2 (BL)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view of the scheduler rules
    logic [1:0] m_gnt;
    logic       m_commit;
    logic       m_pending;
    cfg_t       m_shadow;
    cfg_t       m_active;
    int         m_last;
    logic       m_vbprev;
    int         m_frames;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_gnt     = 2'b00;
            m_commit  = 1'b0;
            m_pending = 1'b0;
            m_shadow  = RSTV;
            m_active  = RSTV;
            m_last    = 0;
            m_vbprev  = 1'b1;
            m_frames  = 0;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            logic       vb;
            logic       rise;
            logic [1:0] want;
            int         w;
            vb       = (int'(bus.py) >= 480);
            rise     = vb && !m_vbprev;
            m_vbprev = vb;
            // whoever was just granted is still dropping its request
            want = bus.req & ~m_gnt;
            w = -1;
            if (want == 2'b11)  w = (m_last == 0) ? 1 : 0;
            else if (want[0])   w = 0;
            else if (want[1])   w = 1;
            m_commit = rise && m_pending;
            if (m_commit) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (w >= 0) begin
                m_shadow  = (w == 1) ? bus.cfg_in1 : bus.cfg_in0;
                m_last    = w;
                m_gnt     = 2'b01 << w;
                m_pending = 1'b1;
            end else begin
                m_gnt = 2'b00;
            end
            if (rise) m_frames++;
        end
    end

    function automatic cfg_t exp_out();
        cfg_t c;
        c = m_active;
`ifdef VGA_CFG_BLINK_EN
        if (((m_frames >> BL) & 1) != 0) c.rgb = 3'b000;
`endif
        return c;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("gnt",     32'(bus.gnt),     32'(m_gnt));
            chk("commit",  32'(bus.commit),  32'(m_commit));
            chk("pending", 32'(bus.pending), 32'(m_pending));
            chk("cfg_out", 32'(bus.cfg_out), 32'(exp_out()));
        end
    end

    // Advance one clock; a requester drops req once it sees its grant.
    task automatic step();
        @(posedge clk);
        #2;
        if (bus.gnt[0]) bus.req[0] = 1'b0;
        if (bus.gnt[1]) bus.req[1] = 1'b0;
    endtask

    initial begin
        int         py_i;
        logic [22:0] rv;

        rst         = 1'b1;
        bus.py      = 10'd100;
        bus.req     = 2'b00;
        bus.cfg_in0 = '0;
        bus.cfg_in1 = '0;
        step();
        step();
        rst = 1'b0;

        // 1: reset state, vblank right after reset does not commit
        chk("t1_cfg_rst",  32'(bus.cfg_out), 32'h0070_0000);
        chk("t1_pend_rst", 32'(bus.pending), 32'd0);
        bus.py = 10'd480;
        step();
        chk("t1_no_commit", 32'(bus.commit), 32'd0);
        step();

        // 2: single request, commit at vblank entry
        bus.py = 10'd200;
        step();
        bus.cfg_in0 = W1;
        bus.req     = 2'b01;
        step();
        chk("t2_gnt",  32'(bus.gnt),     32'd1);
        chk("t2_pend", 32'(bus.pending), 32'd1);
        step();
        bus.py = 10'd479;
        step();
        chk("t2_cfg_hold", 32'(bus.cfg_out), 32'h0070_0000);
        bus.py = 10'd480;
        step();
        chk("t2_commit",  32'(bus.commit),  32'd1);
        chk("t2_cfg",     32'(bus.cfg_out), 32'h0010_2814);
        chk("t2_pend0",   32'(bus.pending), 32'd0);
        step();
        chk("t2_commit_once", 32'(bus.commit), 32'd0);

        // 3: both request, rr_ptr=0 -> requester 1 then requester 0
        bus.py = 10'd10;
        step();
        bus.cfg_in0 = W2;
        bus.cfg_in1 = W3;
        bus.req     = 2'b11;
        step();
        chk("t3_gnt_a", 32'(bus.gnt), 32'd2);
        step();
        chk("t3_gnt_b", 32'(bus.gnt), 32'd1);
        step();
        chk("t3_pend", 32'(bus.pending), 32'd1);
        bus.py = 10'd480;
        step();
        chk("t3_cfg", 32'(bus.cfg_out), 32'(W2));

        // 4: grant on the commit edge
        bus.py = 10'd10;
        step();
        bus.cfg_in0 = W4;
        bus.req     = 2'b01;
        step();
        bus.py = 10'd479;
        step();
        bus.py      = 10'd480;
        bus.cfg_in1 = W5;
        bus.req     = 2'b10;
        step();
        chk("t4_commit", 32'(bus.commit),  32'd1);
        chk("t4_cfg",    32'(bus.cfg_out), 32'(W4));
        chk("t4_gnt",    32'(bus.gnt),     32'd2);
        chk("t4_pend",   32'(bus.pending), 32'd1);
        step();
        chk("t4_pend_kept", 32'(bus.pending), 32'd1);
        bus.py = 10'd10;
        step();
        bus.py = 10'd480;
        step();
        chk("t4_cfg_next", 32'(bus.cfg_out), 32'(W5));
        chk("t4_pend_clr", 32'(bus.pending), 32'd0);

        // 5: reset while pending discards the shadow
        bus.py = 10'd10;
        step();
        bus.cfg_in0 = W6;
        bus.req     = 2'b01;
        step();
        chk("t5_pend", 32'(bus.pending), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_cfg_rst", 32'(bus.cfg_out), 32'h0070_0000);
        chk("t5_pend0",   32'(bus.pending), 32'd0);
        step();
        bus.py = 10'd480;
        step();
        chk("t5_no_commit", 32'(bus.commit),  32'd0);
        chk("t5_cfg_keep",  32'(bus.cfg_out), 32'h0070_0000);
        step();

`ifdef VGA_CFG_BLINK_EN
        // 6: blink gating of rgb only
        rst    = 1'b1;
        bus.py = 10'd10;
        step();
        rst = 1'b0;
        step();
        bus.cfg_in0 = W1;
        bus.req     = 2'b01;
        step();
        bus.py = 10'd480;
        step();
        chk("t6_first", 32'(bus.cfg_out), 32'(W1));
        bus.py = 10'd10;
        step();
        bus.py = 10'd480;
        step();
        chk("t6_blank", 32'(bus.cfg_out), 32'h0000_2814);
        for (int i = 0; i < 2; i++) begin
            bus.py = 10'd10;
            step();
            bus.py = 10'd480;
            step();
        end
        chk("t6_restore", 32'(bus.cfg_out), 32'(W1));
`endif

        // Random traffic checked cycle-by-cycle against the model
        py_i = 0;
        for (int c = 0; c < 4000; c++) begin
            rst  = ($urandom_range(0, 599) == 0);
            py_i = (py_i + int'($urandom_range(0, 40))) % 525;
            bus.py = py_i[9:0];
            if (!bus.req[0] && $urandom_range(0, 5) == 0) begin
                rv = 23'($urandom);
                bus.cfg_in0 = rv;
                bus.req[0]  = 1'b1;
            end
            if (!bus.req[1] && $urandom_range(0, 5) == 0) begin
                rv = 23'($urandom);
                bus.cfg_in1 = rv;
                bus.req[1]  = 1'b1;
            end
            step();
        end
        rst = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
